// File: rtl/foh_pkg.sv
// Shared definitions for the FOH interpolation serial link.
// Word width default matches the transmit shift register.
package foh_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/serial_word_rx_sipo_shift_core.sv
// Serial-in shift register; CLR restarts the word so the incoming bit lands on a zeroed register.
module sipo_shift_core #(
  parameter int DATA_WIDTH = 16,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  CLR,
  input  logic                  SIN,
  output logic [DATA_WIDTH-1:0] Q
);

  logic [DATA_WIDTH-1:0] r_q;
  logic [DATA_WIDTH-1:0] w_base;
  logic [DATA_WIDTH-1:0] w_next;

  assign w_base = CLR ? '0 : r_q;
  assign w_next = MSB_FIRST ? {w_base[DATA_WIDTH-2:0], SIN}
                            : {SIN, w_base[DATA_WIDTH-1:1]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q <= '0;
    end else if (EN) begin
      r_q <= w_next;
    end
  end

  assign Q = r_q;

endmodule

// File: rtl/serial_word_rx.sv
// Serial word receiver: frames SSYNC-marked bit streams into words and hands them
// to a one-entry valid/ready buffer with sticky overrun and framing-error pulse.
//
//   state    | meaning
//   ---------+--------------------------------------------
//   ST_IDLE  | between words; only SEN with SSYNC starts one
//   ST_SHIFT | word partially received; BUSY is high
module serial_word_rx
  import foh_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SIN,
  input  logic                  SEN,
  input  logic                  SSYNC,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  DVALID,
  input  logic                  DREADY,
  output logic                  BUSY,
  output logic                  FERR,
  output logic                  OVR,
  input  logic                  CLR_OVR
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_ferr;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_dvalid;
  logic                  r_ovr;

  logic                  w_in_word;
  logic                  w_start;
  logic                  w_shift_en;
  logic                  w_last;
  logic                  w_load;
  logic                  w_ovr_set;
  logic [DATA_WIDTH-1:0] w_q;
  logic [DATA_WIDTH-1:0] w_word;

  assign w_in_word  = (r_state == ST_SHIFT);
  assign w_start    = SEN && SSYNC;
  assign w_shift_en = SEN && (SSYNC || w_in_word);
  assign w_last     = w_in_word && SEN && !SSYNC && (r_cnt == LAST_CNT);

  // The final bit is still on SIN at the completion edge, so the word is
  // assembled here rather than read back from the core a cycle late.
  assign w_word = MSB_FIRST ? {w_q[DATA_WIDTH-2:0], SIN}
                            : {SIN, w_q[DATA_WIDTH-1:1]};

  assign w_load    = w_last && (!r_dvalid || DREADY);
  assign w_ovr_set = w_last && r_dvalid && !DREADY;

  sipo_shift_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .MSB_FIRST  (MSB_FIRST)
  ) u_core (
    .CLK (CLK),
    .RST (RST),
    .EN  (w_shift_en),
    .CLR (w_start),
    .SIN (SIN),
    .Q   (w_q)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ferr  <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_cnt   <= CW'(1);
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (SEN) begin
            if (SSYNC) begin
              r_ferr <= 1'b1;
              r_cnt  <= CW'(1);
            end else if (w_last) begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dout   <= '0;
      r_dvalid <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_load) begin
        r_dout   <= w_word;
        r_dvalid <= 1'b1;
      end else if (r_dvalid && DREADY) begin
        r_dvalid <= 1'b0;
      end
      if (w_ovr_set) begin
        r_ovr <= 1'b1;
      end else if (CLR_OVR) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign DOUT   = r_dout;
  assign DVALID = r_dvalid;
  assign BUSY   = w_in_word;
  assign FERR   = r_ferr;
  assign OVR    = r_ovr;

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx: MSB-first and LSB-first instances share one bit stream
// and are compared every cycle against a queue-based word model.
module tb_serial_word_rx;

  logic        clk = 1'b0;
  logic        rst, sin, sen, ssync, dready, clr_ovr;
  logic [15:0] dout_m, dout_l;
  logic        dvalid_m, dvalid_l, busy_m, busy_l, ferr_m, ferr_l, ovr_m, ovr_l;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  bit          q_bits[$];
  bit          m_in_word = 1'b0;
  logic [15:0] m_dout_m = '0, m_dout_l = '0;
  logic        m_valid = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;

  always #5 clk = ~clk;

  serial_word_rx #(.DATA_WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
    .CLK(clk), .RST(rst), .SIN(sin), .SEN(sen), .SSYNC(ssync),
    .DOUT(dout_m), .DVALID(dvalid_m), .DREADY(dready),
    .BUSY(busy_m), .FERR(ferr_m), .OVR(ovr_m), .CLR_OVR(clr_ovr)
  );

  serial_word_rx #(.DATA_WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
    .CLK(clk), .RST(rst), .SIN(sin), .SEN(sen), .SSYNC(ssync),
    .DOUT(dout_l), .DVALID(dvalid_l), .DREADY(dready),
    .BUSY(busy_l), .FERR(ferr_l), .OVR(ovr_l), .CLR_OVR(clr_ovr)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_step(input logic s_sin, input logic s_sen, input logic s_ssync,
                            input logic s_dready, input logic s_clr, input logic s_rst);
    bit          done;
    bit          set_ovr;
    logic [15:0] wm, wl;
    done = 1'b0;
    set_ovr = 1'b0;
    wm = '0;
    wl = '0;
    if (s_rst) begin
      q_bits.delete();
      m_in_word = 1'b0;
      m_dout_m = '0;
      m_dout_l = '0;
      m_valid = 1'b0;
      m_ferr = 1'b0;
      m_ovr = 1'b0;
      return;
    end
    m_ferr = 1'b0;
    if (s_sen) begin
      if (s_ssync) begin
        if (m_in_word) m_ferr = 1'b1;
        q_bits.delete();
        q_bits.push_back(s_sin);
        m_in_word = 1'b1;
      end else if (m_in_word) begin
        q_bits.push_back(s_sin);
      end
      if (m_in_word && q_bits.size() == 16) begin
        for (int i = 0; i < 16; i++) begin
          wm[15-i] = q_bits[i];
          wl[i]    = q_bits[i];
        end
        done = 1'b1;
        q_bits.delete();
        m_in_word = 1'b0;
      end
    end
    if (done) begin
      if (!m_valid || s_dready) begin
        m_dout_m = wm;
        m_dout_l = wl;
        m_valid = 1'b1;
      end else begin
        set_ovr = 1'b1;
      end
    end else if (m_valid && s_dready) begin
      m_valid = 1'b0;
    end
    if (set_ovr) m_ovr = 1'b1;
    else if (s_clr) m_ovr = 1'b0;
  endtask

  task automatic compare_all();
    check_eq("dout_msb",   32'(dout_m),   32'(m_dout_m));
    check_eq("dout_lsb",   32'(dout_l),   32'(m_dout_l));
    check_eq("dvalid_msb", 32'(dvalid_m), 32'(m_valid));
    check_eq("dvalid_lsb", 32'(dvalid_l), 32'(m_valid));
    check_eq("busy_msb",   32'(busy_m),   32'(m_in_word));
    check_eq("busy_lsb",   32'(busy_l),   32'(m_in_word));
    check_eq("ferr_msb",   32'(ferr_m),   32'(m_ferr));
    check_eq("ferr_lsb",   32'(ferr_l),   32'(m_ferr));
    check_eq("ovr_msb",    32'(ovr_m),    32'(m_ovr));
    check_eq("ovr_lsb",    32'(ovr_l),    32'(m_ovr));
  endtask

  task automatic step(input logic s_sin, input logic s_sen, input logic s_ssync,
                      input logic s_dready, input logic s_clr, input logic s_rst);
    sin = s_sin;
    sen = s_sen;
    ssync = s_ssync;
    dready = s_dready;
    clr_ovr = s_clr;
    rst = s_rst;
    @(posedge clk);
    model_step(s_sin, s_sen, s_ssync, s_dready, s_clr, s_rst);
    #1;
    compare_all();
  endtask

  task automatic send_word(input logic [15:0] w, input bit lsb_first, input bit gap,
                           input logic dr_body, input logic dr_last, input logic clr_last,
                           output int busy_cnt);
    logic b;
    busy_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      b = lsb_first ? w[i] : w[15-i];
      if (i == 15) step(b, 1'b1, 1'b0, dr_last, clr_last, 1'b0);
      else         step(b, 1'b1, (i == 0), dr_body, 1'b0, 1'b0);
      if (busy_m) busy_cnt++;
      if (gap && i != 15) step(1'b0, 1'b0, 1'b0, dr_body, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int          bc;
    logic [15:0] junk;
    junk = 16'h6B3D;

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("reset_dvalid", 32'(dvalid_m), 32'd0);
    check_eq("reset_dout",   32'(dout_m),   32'd0);

    // basic MSB-first word, back-to-back bits
    send_word(16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, bc);
    check_eq("t1_dout",        32'(dout_m),   32'h0000_A5C3);
    check_eq("t1_dvalid",      32'(dvalid_m), 32'd1);
    check_eq("t1_busy_cycles", 32'(bc),       32'd15);

    // stray bit then gapped LSB-first word
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("t2_stray_busy", 32'(busy_l), 32'd0);
    send_word(16'h1234, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, bc);
    check_eq("t2_dout", 32'(dout_l), 32'h0000_1234);

    // back-pressure overrun, clear, then set/clear collision
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_word(16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, bc);
    send_word(16'hFF00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, bc);
    check_eq("t3_dout_held", 32'(dout_m), 32'h0000_00FF);
    check_eq("t3_ovr_set",   32'(ovr_m),  32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("t3_ovr_clr",   32'(ovr_m),  32'd0);
    send_word(16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, bc);
    check_eq("t3_ovr_collide", 32'(ovr_m), 32'd1);

    // same-cycle refill
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_word(16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, bc);
    send_word(16'h2222, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, bc);
    check_eq("t4_dout",   32'(dout_m),   32'h0000_2222);
    check_eq("t4_dvalid", 32'(dvalid_m), 32'd1);
    check_eq("t4_ovr",    32'(ovr_m),    32'd0);

    // framing error: 7 bits, then restart with 0xBEEF
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(junk[15-i], 1'b1, (i == 0), 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("t5_ferr_pulse", 32'(ferr_m),   32'd1);
    check_eq("t5_no_partial", 32'(dvalid_m), 32'd0);
    for (int i = 1; i < 16; i++) begin
      step(sin_bit(16'hBEEF, i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 1) check_eq("t5_ferr_cleared", 32'(ferr_m), 32'd0);
    end
    check_eq("t5_dout", 32'(dout_m), 32'h0000_BEEF);

    // reset mid-word, then a clean word
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(junk[i], 1'b1, (i == 0), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("t6_rst_busy", 32'(busy_m), 32'd0);
    check_eq("t6_rst_dout", 32'(dout_m), 32'd0);
    send_word(16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, bc);
    check_eq("t6_dout", 32'(dout_m), 32'h0000_5A5A);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      logic r_sen;
      r_sen = ($urandom_range(3) != 0);
      step(1'($urandom_range(1)), r_sen, r_sen && ($urandom_range(11) == 0),
           ($urandom_range(2) != 0), ($urandom_range(15) == 0), ($urandom_range(499) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  function automatic logic sin_bit(input logic [15:0] w, input int i);
    return w[15-i];
  endfunction

endmodule
